// File: rtl/reaction_ctrl_if.sv
// Front-panel bundle for the reaction timer: button pulses and the go_buffs
// level in, display-facing state, times and flags out.
interface reaction_ctrl_if #(
  parameter int TIME_W = 14
);
  logic              start_btn;
  logic              stop_btn;
  logic              go_buffs;
  logic [2:0]        state;
  logic              led_go;
  logic [TIME_W-1:0] time_ms;
  logic [TIME_W-1:0] hi_score_ms;
  logic              new_hi;
  logic              false_start;

  modport master (
    output start_btn, stop_btn, go_buffs,
    input  state, led_go, time_ms, hi_score_ms, new_hi, false_start
  );

  modport slave (
    input  start_btn, stop_btn, go_buffs,
    output state, led_go, time_ms, hi_score_ms, new_hi, false_start
  );
endinterface

// File: rtl/reaction_ctrl.sv
// Reaction-time game controller: LFSR-randomised pre-go delay, ms timing, best score.
// Define REACTION_CTRL_FALSE_START_EN to turn a stop press during the delay into a FAULT.
module reaction_ctrl #(
  parameter int              TICK_DIV     = 50000,
  parameter int              TIME_W       = 14,
  parameter int              LFSR_W       = 10,
  parameter logic [LFSR_W-1:0] LFSR_TAPS  = 10'h240,
  parameter int              DELAY_MIN_MS = 1000
) (
  input  logic           clk,
  input  logic           rst,
  reaction_ctrl_if.slave bus
);

`ifdef REACTION_CTRL_FALSE_START_EN
  localparam bit FALSE_START_EN = 1'b1;
`else
  localparam bit FALSE_START_EN = 1'b0;
`endif

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DLY_W = ((TIME_W > LFSR_W) ? TIME_W : LFSR_W) + 1;
  localparam logic [TIME_W-1:0] TIME_MAX = '1;
  localparam logic [TIME_W-1:0] TIME_PRE_SAT = TIME_MAX - 1'b1;

  typedef enum logic [2:0] {
    HI_SCORE = 3'b000,
    DELAYING = 3'b001,
    TIMING   = 3'b010,
    DISPLAY  = 3'b011,
    GO_BUFFS = 3'b100,
    FAULT    = 3'b101
  } state_t;

  state_t            state_q, state_next;
  logic [LFSR_W-1:0] lfsr_q, lfsr_next;
  logic [PRE_W-1:0]  presc_q;
  logic [DLY_W-1:0]  delay_q;
  logic [TIME_W-1:0] time_q, hi_q;
  logic              new_hi_q;
  logic              tick;
  logic              load_round, enter_timing, count_tick, stop_hit;

  assign tick = (presc_q == PRE_W'(TICK_DIV - 1));

  // Shifting out the top tap bit keeps the map invertible; the zero guard is a safety net.
  always_comb begin
    lfsr_next = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    if (lfsr_next == '0) lfsr_next = '1;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= HI_SCORE;
    else     state_q <= state_next;
  end

  always_comb begin
    state_next   = state_q;
    load_round   = 1'b0;
    enter_timing = 1'b0;
    count_tick   = 1'b0;
    stop_hit     = 1'b0;
    if (bus.go_buffs) begin
      state_next = GO_BUFFS;
    end else begin
      case (state_q)
        HI_SCORE: if (bus.start_btn) begin
          state_next = DELAYING;
          load_round = 1'b1;
        end
        DELAYING: begin
          if (FALSE_START_EN && bus.stop_btn) begin
            state_next = FAULT;
          end else if (tick && delay_q == DLY_W'(1)) begin
            state_next   = TIMING;
            enter_timing = 1'b1;
          end
        end
        TIMING: begin
          // A stop on the same cycle as a tick wins and that tick is dropped.
          if (bus.stop_btn) begin
            state_next = DISPLAY;
            stop_hit   = 1'b1;
          end else if (tick) begin
            count_tick = 1'b1;
            if (time_q == TIME_PRE_SAT) state_next = DISPLAY;
          end
        end
        DISPLAY: begin
          if (bus.stop_btn) begin
            state_next = HI_SCORE;
          end else if (bus.start_btn) begin
            state_next = DELAYING;
            load_round = 1'b1;
          end
        end
        GO_BUFFS: state_next = HI_SCORE;
        FAULT: if (bus.start_btn) begin
          state_next = DELAYING;
          load_round = 1'b1;
        end
        default: state_next = HI_SCORE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q   <= '1;
      presc_q  <= '0;
      delay_q  <= '0;
      time_q   <= '0;
      hi_q     <= '1;
      new_hi_q <= 1'b0;
    end else begin
      lfsr_q <= lfsr_next;

      if (load_round || enter_timing || tick) presc_q <= '0;
      else                                    presc_q <= presc_q + 1'b1;

      if (load_round)
        delay_q <= DLY_W'(DELAY_MIN_MS) + DLY_W'(lfsr_q);
      else if (state_q == DELAYING && tick && delay_q != '0)
        delay_q <= delay_q - 1'b1;

      if (load_round)      time_q <= '0;
      else if (count_tick) time_q <= time_q + 1'b1;

      if (load_round) begin
        new_hi_q <= 1'b0;
      end else if (stop_hit && time_q < hi_q) begin
        hi_q     <= time_q;
        new_hi_q <= 1'b1;
      end
    end
  end

  assign bus.state       = state_q;
  assign bus.led_go      = (state_q == TIMING);
  assign bus.time_ms     = time_q;
  assign bus.hi_score_ms = hi_q;
  assign bus.new_hi      = new_hi_q && (state_q == DISPLAY);
  assign bus.false_start = FALSE_START_EN && (state_q == FAULT);

endmodule

// File: tb/tb_reaction_ctrl.sv
// Self-checking bench for reaction_ctrl with a short tick (4 clocks) and 8-bit times;
// rounds are predicted from the LFSR rule, tick arithmetic and a running best score.
module tb_reaction_ctrl;
  localparam int TICK_DIV  = 4;
  localparam int DELAY_MIN = 3;
  localparam int TIME_W    = 8;
  localparam int SAT       = 255;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  int   m_hi;
  logic [9:0] m_lfsr;

  reaction_ctrl_if #(.TIME_W(TIME_W)) bus();

  reaction_ctrl #(
    .TICK_DIV(TICK_DIV),
    .TIME_W(TIME_W),
    .DELAY_MIN_MS(DELAY_MIN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference random source: value the design sees at each edge, advanced by the tap rule.
  function automatic logic [9:0] lfsr_step(input logic [9:0] v);
    int parity;
    parity = $countones(v & 10'h240) % 2;
    return 10'(((int'(v) * 2) % 1024) + parity);
  endfunction

  always @(posedge clk) begin
    if (rst) m_lfsr <= 10'h3ff;
    else     m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    bus.start_btn = 1'b1;
    step();
    bus.start_btn = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop_btn = 1'b1;
    step();
    bus.stop_btn = 1'b0;
  endtask

  // Press start (optionally when the random source shows a chosen value), reach TIMING,
  // then either stop after w cycles or let the counter run out.
  task automatic apply_stimulus(input int idle, input int want, input int w, input bit do_stop);
    int n;
    int dly;
    int t;
    bit nh;
    for (int i = 0; i < idle; i++) step();
    if (want >= 0) begin
      n = 0;
      while (int'(m_lfsr) != want && n < 1100) begin
        step();
        n++;
      end
      check_output("lfsr_reached", 32'(int'(m_lfsr) == want), 32'd1);
    end
    dly = DELAY_MIN + int'(m_lfsr);
    pulse_start();
    check_output("enter_delaying", 32'(bus.state), 32'd1);
    check_output("time_cleared", 32'(bus.time_ms), 32'd0);
    n = 0;
    while (bus.state !== 3'b010 && n < 5000) begin
      step();
      n++;
    end
    check_output("timing_latency", 32'(n), 32'(dly * TICK_DIV));
    check_output("led_go_on", 32'(bus.led_go), 32'd1);
    if (do_stop) begin
      for (int i = 0; i < w; i++) step();
      pulse_stop();
      t  = w / TICK_DIV;
      nh = (t < m_hi);
      if (nh) m_hi = t;
    end else begin
      n = 0;
      while (bus.state !== 3'b011 && n < 1100) begin
        step();
        n++;
      end
      t  = SAT;
      nh = 1'b0;
    end
    check_output("display_state", 32'(bus.state), 32'd3);
    check_output("time_ms", 32'(bus.time_ms), 32'(t));
    check_output("hi_score", 32'(bus.hi_score_ms), 32'(m_hi));
    check_output("new_hi", 32'(bus.new_hi), 32'(nh));
    check_output("led_go_off", 32'(bus.led_go), 32'd0);
  endtask

  initial begin
    int n;
    bus.start_btn = 1'b0;
    bus.stop_btn  = 1'b0;
    bus.go_buffs  = 1'b0;
    rst  = 1'b1;
    m_hi = SAT;
    step();
    step();
    rst = 1'b0;

    check_output("rst_state", 32'(bus.state), 32'd0);
    check_output("rst_led_go", 32'(bus.led_go), 32'd0);
    check_output("rst_time", 32'(bus.time_ms), 32'd0);
    check_output("rst_hi", 32'(bus.hi_score_ms), 32'(SAT));
    check_output("rst_new_hi", 32'(bus.new_hi), 32'd0);
    check_output("rst_false_start", 32'(bus.false_start), 32'd0);

    // Stop is ignored while idle.
    pulse_stop();
    check_output("idle_stop_ignored", 32'(bus.state), 32'd0);

    $display("[TB] round with LFSR=2, stop after 7 ticks");
    apply_stimulus(0, 2, 28, 1'b1);
    pulse_stop();
    check_output("display_to_hiscore", 32'(bus.state), 32'd0);
    check_output("new_hi_cleared", 32'(bus.new_hi), 32'd0);

    $display("[TB] slower round of 9 ticks");
    apply_stimulus(3, -1, 36, 1'b1);

    $display("[TB] stop coincident with 5th tick");
    apply_stimulus(0, -1, 19, 1'b1);

    $display("[TB] no stop, saturation");
    pulse_stop();
    apply_stimulus(2, -1, 0, 1'b0);

    // Start and stop together in DISPLAY: stop wins.
    bus.start_btn = 1'b1;
    bus.stop_btn  = 1'b1;
    step();
    bus.start_btn = 1'b0;
    bus.stop_btn  = 1'b0;
    check_output("both_in_display", 32'(bus.state), 32'd0);

    $display("[TB] randomised rounds");
    for (int r = 0; r < 5; r++) begin
      apply_stimulus(int'($urandom_range(0, 40)), -1, int'($urandom_range(0, 200)), 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        pulse_stop();
        check_output("rand_to_hiscore", 32'(bus.state), 32'd0);
      end
    end

    $display("[TB] go_buffs mid-TIMING");
    if (bus.state === 3'b011) begin
      pulse_stop();
    end
    pulse_start();
    n = 0;
    while (bus.state !== 3'b010 && n < 5000) begin
      step();
      n++;
    end
    check_output("gb_reached_timing", 32'(bus.state), 32'd2);
    for (int i = 0; i < 6; i++) step();
    bus.go_buffs = 1'b1;
    step();
    check_output("gb_state", 32'(bus.state), 32'd4);
    check_output("gb_led_go", 32'(bus.led_go), 32'd0);
    bus.start_btn = 1'b1;
    step();
    step();
    bus.start_btn = 1'b0;
    check_output("gb_held", 32'(bus.state), 32'd4);
    bus.go_buffs = 1'b0;
    step();
    check_output("gb_release", 32'(bus.state), 32'd0);
    check_output("gb_hi_kept", 32'(bus.hi_score_ms), 32'(m_hi));

    $display("[TB] stop during the delay");
    pulse_start();
    check_output("fs_delaying", 32'(bus.state), 32'd1);
    step();
    pulse_stop();
`ifdef REACTION_CTRL_FALSE_START_EN
    check_output("fs_state", 32'(bus.state), 32'd5);
    check_output("fs_flag", 32'(bus.false_start), 32'd1);
`else
    check_output("fs_state", 32'(bus.state), 32'd1);
    check_output("fs_flag", 32'(bus.false_start), 32'd0);
`endif

    // Reset aborts the round and forgets the best score.
    rst = 1'b1;
    bus.go_buffs = 1'b1;
    step();
    rst = 1'b0;
    bus.go_buffs = 1'b0;
    m_hi = SAT;
    check_output("abort_state", 32'(bus.state), 32'd0);
    check_output("abort_hi", 32'(bus.hi_score_ms), 32'(SAT));
    check_output("abort_led_go", 32'(bus.led_go), 32'd0);
    check_output("abort_false_start", 32'(bus.false_start), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
